// File: rtl/ofm_pkg.sv
// Shared widths, pixel types and the round/shift/saturate helper for the OFM output path.
package ofm_pkg;

  localparam int OFM_IN_W  = 13;
  localparam int OFM_OUT_W = 8;
  localparam int OFM_SHIFT = 7;
  localparam int OFM_ACC_N = 4;

  typedef logic [OFM_IN_W-1:0]  ofm_t;
  typedef logic [OFM_OUT_W-1:0] pix_t;

  // Round half-up, shift right, clamp to an unsigned out_w-bit range.
  function automatic logic [31:0] rnd_sat(input logic [31:0] sum,
                                          input int unsigned shift,
                                          input int unsigned out_w);
    logic [32:0] r;
    logic [32:0] mx;
    r  = ({1'b0, sum} + (33'd1 << (shift - 1))) >> shift;
    mx = (33'd1 << out_w) - 33'd1;
    if (r > mx) r = mx;
    return r[31:0];
  endfunction

endpackage

// File: rtl/ofm_fifo.sv
// Synchronous FIFO with a registered head word; push into a full FIFO is accepted only alongside a pop.
// Head is visible one cycle after a push into an empty FIFO; head holds while empty.
module ofm_fifo
  import ofm_pkg::*;
#(
  parameter int W     = OFM_OUT_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic [W-1:0]     head_dat
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [W-1:0]     head_q, head_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (lvl_q == LVL_W'(DEPTH));
  assign empty    = (lvl_q == '0);
  assign level    = lvl_q;
  assign head_dat = head_q;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    head_d  = head_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (do_pop) rd_d = rd_q + PTR_W'(1);
    if (do_push && !do_pop)      lvl_d = lvl_q + LVL_W'(1);
    else if (do_pop && !do_push) lvl_d = lvl_q - LVL_W'(1);
    // Head register tracks the post-update head so o_data needs no read mux at the port.
    if (lvl_d != '0) head_d = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/ofm_accum_quant.sv
// Sums ACC_N OFM partial sums per pixel, rounds/shifts/saturates, queues results; OFM_BIAS_EN adds a per-pixel bias.
// o_valid rises 1 cycle after the last sample; no upstream backpressure, a push into a full FIFO drops and sets ovf.
module ofm_accum_quant
  import ofm_pkg::*;
#(
  parameter int IN_W  = OFM_IN_W,
  parameter int ACC_N = OFM_ACC_N,
  parameter int SHIFT = OFM_SHIFT,
  parameter int OUT_W = OFM_OUT_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IN_W-1:0]        in_ofm,
  input  logic                   frame_start,
`ifdef OFM_BIAS_EN
  input  logic [OUT_W-1:0]       bias,
`endif
  input  logic                   o_ready,
  output logic                   o_valid,
  output logic [OUT_W-1:0]       o_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int CNT_W = $clog2(ACC_N);
  localparam int ACC_W = IN_W + CNT_W;
`ifdef OFM_BIAS_EN
  localparam int SUM_W = ACC_W + 2;
`else
  localparam int SUM_W = ACC_W + 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_N - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum;
  logic [OUT_W-1:0] pix;
  logic             grp_done;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  always_comb begin
    sum = SUM_W'(acc_q) + SUM_W'(in_ofm);
`ifdef OFM_BIAS_EN
    sum = sum + SUM_W'(bias);
`endif
    pix = OUT_W'(rnd_sat(32'(sum), SHIFT, OUT_W));
  end

  assign o_valid = !fifo_empty;
  assign pop     = o_valid && o_ready;
  assign ovf     = ovf_q;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    grp_done = in_valid && !frame_start && (cnt_q == CNT_LAST);
    // A sample arriving with frame_start opens the new group rather than closing the old one.
    if (frame_start) begin
      cnt_d = '0;
      if (in_valid) begin
        acc_d = ACC_W'(in_ofm);
        cnt_d = CNT_W'(1);
      end
    end else if (in_valid) begin
      acc_d = (cnt_q == '0) ? ACC_W'(in_ofm) : acc_q + ACC_W'(in_ofm);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (grp_done && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  ofm_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (grp_done),
    .push_dat (pix),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .head_dat (o_data)
  );

endmodule
